// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared piece, command, board and spawn definitions
//
// Piece type codes, move command codes, board geometry, spawn position and
// the controller's internal state/operation encodings.

package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;

    localparam logic [4:0] SPAWN_X = 5'd3;
    localparam logic [5:0] SPAWN_Y = 6'd0;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_J = 3'd1,
        PIECE_L = 3'd2,
        PIECE_O = 3'd3,
        PIECE_S = 3'd4,
        PIECE_T = 3'd5,
        PIECE_Z = 3'd6
    } piece_t;

    typedef enum logic [2:0] {
        CMD_LEFT      = 3'd0,
        CMD_RIGHT     = 3'd1,
        CMD_ROT_CW    = 3'd2,
        CMD_ROT_CCW   = 3'd3,
        CMD_SOFT_DROP = 3'd4,
        CMD_HARD_DROP = 3'd5
    } cmd_t;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_ACTIVE,
        ST_CHECK,
        ST_LOCK,
        ST_OVER
    } state_t;

    // What the running scan is for; decides where a failed scan goes.
    typedef enum logic [2:0] {
        OP_SPAWN,
        OP_SIDE,
        OP_ROT,
        OP_DOWN,
        OP_HARD
    } op_t;

endpackage

// File: rtl/piece_ctrl_shape.sv
// rtl/piece_ctrl_shape.sv - tetromino shape lookup for one 4x4 grid cell
//
// Ports:
//   piece_type  in  3  piece code (tetris_pkg piece_t); 7 has no cells
//   rot         in  2  rotation state, 0..3, each step clockwise
//   col, row    in  2  cell within the 4x4 shape grid
//   active      out 1  cell is occupied by the piece
//
// Only the spawn orientation is stored. I rotates inside the full 4x4 box,
// O never rotates, the rest rotate inside the top-left 3x3 box. The queried
// cell is rotated back to the spawn frame and looked up there.

module piece_ctrl_shape
    import tetris_pkg::*;
(
    input  logic [2:0] piece_type,
    input  logic [1:0] rot,
    input  logic [1:0] col,
    input  logic [1:0] row,
    output logic       active
);

    // Spawn-orientation masks, bit index = row*4 + col.
    function automatic logic [15:0] base_mask(input logic [2:0] t);
        case (t)
            PIECE_I: base_mask = 16'h00F0;
            PIECE_J: base_mask = 16'h0071;
            PIECE_L: base_mask = 16'h0074;
            PIECE_O: base_mask = 16'h0066;
            PIECE_S: base_mask = 16'h0036;
            PIECE_T: base_mask = 16'h0072;
            PIECE_Z: base_mask = 16'h0063;
            default: base_mask = 16'h0000;
        endcase
    endfunction

    logic [1:0]  r;
    logic [1:0]  c;
    logic [1:0]  tmp;
    logic [1:0]  span;
    logic        in_box;
    logic [15:0] mask;

    always_comb begin
        r      = row;
        c      = col;
        tmp    = 2'd0;
        span   = (piece_type == PIECE_I) ? 2'd3 : 2'd2;
        in_box = (piece_type == PIECE_I) || (row != 2'd3 && col != 2'd3);
        mask   = base_mask(piece_type);
        // One clockwise step maps (r,c) -> (c, span-r); undo it rot times.
        if (piece_type != PIECE_O) begin
            for (int i = 0; i < 3; i++) begin
                if (i < int'(rot)) begin
                    tmp = r;
                    r   = span - c;
                    c   = tmp;
                end
            end
        end
        active = in_box && mask[{r, c}];
    end

endmodule

// File: rtl/piece_ctrl.sv
// rtl/piece_ctrl.sv - active tetromino controller: spawn, move, collision scan, lock
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   spawn_valid/ready, spawn_type new-piece handshake and piece code
//   cmd_valid/ready, cmd          move handshake (LEFT..HARD_DROP, 6-7 no-op)
//   grav_tick                     one-cycle gravity pulse
//   probe_x, probe_y, probe_hit   board occupancy query, answered same cycle
//   cur_type/rot/x/y, cur_live    committed active piece (x, y two's complement)
//   lock_valid, lock_ack          piece-lock handshake to the board merger
//   game_over                     sticky until reset
//
// Build option: PIECE_CTRL_WALLKICK_EN retries a failed rotation at x-1,
// then x+1, before discarding it.
//
// Every move is staged in cand_* and checked one shape cell per cycle
// against the board; cur_* only changes when all 16 cells pass.

module piece_ctrl
    import tetris_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       spawn_valid,
    output logic       spawn_ready,
    input  logic [2:0] spawn_type,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd,
    input  logic       grav_tick,
    output logic [3:0] probe_x,
    output logic [4:0] probe_y,
    input  logic       probe_hit,
    output logic [2:0] cur_type,
    output logic [1:0] cur_rot,
    output logic [4:0] cur_x,
    output logic [5:0] cur_y,
    output logic       cur_live,
    output logic       lock_valid,
    input  logic       lock_ack,
    output logic       game_over
);

    localparam logic [5:0] BX_MAX = 6'(BOARD_W - 1);
    localparam logic [6:0] BY_MAX = 7'(BOARD_H - 1);

    state_t     state_q, state_n;
    op_t        op_q, op_n;
    logic [3:0] idx_q, idx_n;
    logic       pend_q, pend_n;
    logic [2:0] cand_type_q, cand_type_n;
    logic [1:0] cand_rot_q, cand_rot_n;
    logic [4:0] cand_x_q, cand_x_n;
    logic [5:0] cand_y_q, cand_y_n;
    logic [2:0] cur_type_n;
    logic [1:0] cur_rot_n;
    logic [4:0] cur_x_n;
    logic [5:0] cur_y_n;
    logic       cur_live_n;
`ifdef PIECE_CTRL_WALLKICK_EN
    logic [1:0] kick_q, kick_n;
`endif

    logic       shape_on;
    logic [5:0] bx;
    logic [6:0] by;
    logic       cell_fail;

    piece_ctrl_shape u_shape (
        .piece_type (cand_type_q),
        .rot        (cand_rot_q),
        .col        (idx_q[1:0]),
        .row        (idx_q[3:2]),
        .active     (shape_on)
    );

    // Sign-extended board coordinates of the scanned cell.
    assign bx = {cand_x_q[4], cand_x_q} + {4'b0000, idx_q[1:0]};
    assign by = {cand_y_q[5], cand_y_q} + {5'b00000, idx_q[3:2]};

    assign probe_x = bx[3:0];
    assign probe_y = by[4:0];

    // Cells above the board never collide; probe_hit only matters once the
    // cell is known to be on the board (bx[5]/by[6] are the sign bits).
    assign cell_fail = shape_on && !by[6] &&
                       (bx[5] || (bx > BX_MAX) || (by > BY_MAX) || probe_hit);

    always_comb begin
        state_n     = state_q;
        op_n        = op_q;
        idx_n       = idx_q;
        pend_n      = pend_q;
        cand_type_n = cand_type_q;
        cand_rot_n  = cand_rot_q;
        cand_x_n    = cand_x_q;
        cand_y_n    = cand_y_q;
        cur_type_n  = cur_type;
        cur_rot_n   = cur_rot;
        cur_x_n     = cur_x;
        cur_y_n     = cur_y;
        cur_live_n  = cur_live;
`ifdef PIECE_CTRL_WALLKICK_EN
        kick_n      = kick_q;
`endif
        spawn_ready = 1'b0;
        cmd_ready   = 1'b0;
        lock_valid  = 1'b0;
        game_over   = 1'b0;

        // Ticks outside ACTIVE are remembered (merged) and served later.
        if (grav_tick && state_q != ST_ACTIVE) begin
            pend_n = 1'b1;
        end

        case (state_q)
            ST_EMPTY: begin
                spawn_ready = 1'b1;
                if (spawn_valid) begin
                    cand_type_n = spawn_type;
                    cand_rot_n  = 2'd0;
                    cand_x_n    = SPAWN_X;
                    cand_y_n    = SPAWN_Y;
                    op_n        = OP_SPAWN;
                    idx_n       = 4'd0;
                    state_n     = ST_CHECK;
                end
            end

            ST_ACTIVE: begin
                cmd_ready   = !pend_q && !grav_tick;
                cand_type_n = cur_type;
                cand_rot_n  = cur_rot;
                cand_x_n    = cur_x;
                cand_y_n    = cur_y;
                idx_n       = 4'd0;
`ifdef PIECE_CTRL_WALLKICK_EN
                kick_n      = 2'd0;
`endif
                if (pend_q || grav_tick) begin
                    pend_n   = 1'b0;
                    cand_y_n = cur_y + 6'd1;
                    op_n     = OP_DOWN;
                    state_n  = ST_CHECK;
                end else if (cmd_valid) begin
                    state_n = ST_CHECK;
                    case (cmd)
                        CMD_LEFT: begin
                            cand_x_n = cur_x - 5'd1;
                            op_n     = OP_SIDE;
                        end
                        CMD_RIGHT: begin
                            cand_x_n = cur_x + 5'd1;
                            op_n     = OP_SIDE;
                        end
                        CMD_ROT_CW: begin
                            cand_rot_n = cur_rot + 2'd1;
                            op_n       = OP_ROT;
                        end
                        CMD_ROT_CCW: begin
                            cand_rot_n = cur_rot - 2'd1;
                            op_n       = OP_ROT;
                        end
                        CMD_SOFT_DROP: begin
                            cand_y_n = cur_y + 6'd1;
                            op_n     = OP_DOWN;
                        end
                        CMD_HARD_DROP: begin
                            cand_y_n = cur_y + 6'd1;
                            op_n     = OP_HARD;
                        end
                        default: state_n = ST_ACTIVE;
                    endcase
                end
            end

            ST_CHECK: begin
                if (cell_fail) begin
                    idx_n = 4'd0;
                    case (op_q)
                        OP_SPAWN:         state_n = ST_OVER;
                        OP_DOWN, OP_HARD: state_n = ST_LOCK;
`ifdef PIECE_CTRL_WALLKICK_EN
                        OP_ROT: begin
                            if (kick_q == 2'd0) begin
                                cand_x_n = cur_x - 5'd1;
                                kick_n   = 2'd1;
                            end else if (kick_q == 2'd1) begin
                                cand_x_n = cur_x + 5'd1;
                                kick_n   = 2'd2;
                            end else begin
                                state_n = ST_ACTIVE;
                            end
                        end
`endif
                        default:          state_n = ST_ACTIVE;
                    endcase
                end else if (idx_q == 4'd15) begin
                    cur_type_n = cand_type_q;
                    cur_rot_n  = cand_rot_q;
                    cur_x_n    = cand_x_q;
                    cur_y_n    = cand_y_q;
                    cur_live_n = 1'b1;
                    idx_n      = 4'd0;
                    // Hard drop keeps stepping down from the row just committed.
                    if (op_q == OP_HARD) begin
                        cand_y_n = cand_y_q + 6'd1;
                    end else begin
                        state_n = ST_ACTIVE;
                    end
                end else begin
                    idx_n = idx_q + 4'd1;
                end
            end

            ST_LOCK: begin
                lock_valid = 1'b1;
                if (lock_ack) begin
                    cur_live_n = 1'b0;
                    state_n    = ST_EMPTY;
                end
            end

            ST_OVER: begin
                game_over = 1'b1;
            end

            default: state_n = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            op_q        <= OP_SPAWN;
            idx_q       <= 4'd0;
            pend_q      <= 1'b0;
            cand_type_q <= 3'd0;
            cand_rot_q  <= 2'd0;
            cand_x_q    <= 5'd0;
            cand_y_q    <= 6'd0;
            cur_type    <= 3'd0;
            cur_rot     <= 2'd0;
            cur_x       <= 5'd0;
            cur_y       <= 6'd0;
            cur_live    <= 1'b0;
`ifdef PIECE_CTRL_WALLKICK_EN
            kick_q      <= 2'd0;
`endif
        end else begin
            state_q     <= state_n;
            op_q        <= op_n;
            idx_q       <= idx_n;
            pend_q      <= pend_n;
            cand_type_q <= cand_type_n;
            cand_rot_q  <= cand_rot_n;
            cand_x_q    <= cand_x_n;
            cand_y_q    <= cand_y_n;
            cur_type    <= cur_type_n;
            cur_rot     <= cur_rot_n;
            cur_x       <= cur_x_n;
            cur_y       <= cur_y_n;
            cur_live    <= cur_live_n;
`ifdef PIECE_CTRL_WALLKICK_EN
            kick_q      <= kick_n;
`endif
        end
    end

endmodule

// File: tb/tb_piece_ctrl.sv
// tb/tb_piece_ctrl.sv - directed self-checking bench for piece_ctrl

module tb_piece_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [2:0] spawn_type;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic       grav_tick;
    logic [3:0] probe_x;
    logic [4:0] probe_y;
    logic       probe_hit;
    logic [2:0] cur_type;
    logic [1:0] cur_rot;
    logic [4:0] cur_x;
    logic [5:0] cur_y;
    logic       cur_live;
    logic       lock_valid;
    logic       lock_ack;
    logic       game_over;

    logic board [0:19][0:9];

    int n_pass  = 0;
    int n_total = 0;
    int n;

    localparam int IDLE_LIMIT = 1000;

    piece_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_type  (spawn_type),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd         (cmd),
        .grav_tick   (grav_tick),
        .probe_x     (probe_x),
        .probe_y     (probe_y),
        .probe_hit   (probe_hit),
        .cur_type    (cur_type),
        .cur_rot     (cur_rot),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .cur_live    (cur_live),
        .lock_valid  (lock_valid),
        .lock_ack    (lock_ack),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    always_comb begin
        probe_hit = 1'b0;
        if (int'(probe_x) < 10 && int'(probe_y) < 20) begin
            probe_hit = board[int'(probe_y)][int'(probe_x)];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges until the controller is waiting for something again.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (!(cmd_ready || lock_valid || spawn_ready || game_over) && cycles < IDLE_LIMIT) begin
            step(1);
            cycles++;
        end
        check("idle_bound", cycles < IDLE_LIMIT, 1);
    endtask

    task automatic do_spawn(input logic [2:0] t);
        int w = 0;
        spawn_type  = t;
        spawn_valid = 1'b1;
        while (!spawn_ready && w < 100) begin
            step(1);
            w++;
        end
        check("spawn_ready_seen", spawn_ready, 1);
        step(1);
        spawn_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] c);
        int w = 0;
        cmd       = c;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 100) begin
            step(1);
            w++;
        end
        check("cmd_ready_seen", cmd_ready, 1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic ack_lock();
        lock_ack = 1'b1;
        step(1);
        lock_ack = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        spawn_valid = 1'b0;
        spawn_type  = 3'd0;
        cmd_valid   = 1'b0;
        cmd         = 3'd0;
        grav_tick   = 1'b0;
        lock_ack    = 1'b0;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                board[y][x] = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);

        // Reset state
        check("rst_spawn_ready", spawn_ready, 1);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_cur_live", cur_live, 0);
        check("rst_lock_valid", lock_valid, 0);
        check("rst_game_over", game_over, 0);
        check("rst_cur_x", cur_x, 0);
        check("rst_cur_y", cur_y, 0);

        // Spawn T on empty board: 16 scan cycles then commit
        do_spawn(3'd5);
        wait_idle(n);
        check("t_spawn_cycles", n, 16);
        check("t_spawn_type", cur_type, 5);
        check("t_spawn_x", cur_x, 3);
        check("t_spawn_y", cur_y, 0);
        check("t_spawn_rot", cur_rot, 0);
        check("t_spawn_live", cur_live, 1);
        check("t_spawn_ready_low", spawn_ready, 0);

        // Rotation wraps both ways
        send_cmd(3'd3);
        wait_idle(n);
        check("rot_ccw_wrap", cur_rot, 3);
        send_cmd(3'd2);
        wait_idle(n);
        check("rot_cw_back", cur_rot, 0);

        // Tick and LEFT in the same cycle: drop first, LEFT held off
        grav_tick = 1'b1;
        cmd       = 3'd0;
        cmd_valid = 1'b1;
        #1;
        check("tick_blocks_cmd", cmd_ready, 0);
        step(1);
        grav_tick = 1'b0;
        check("tick_busy_cmd", cmd_ready, 0);
        wait_idle(n);
        check("tick_drop_cycles", n, 16);
        check("tick_drop_y", cur_y, 1);
        check("tick_drop_x_kept", cur_x, 3);
        step(1);
        cmd_valid = 1'b0;
        wait_idle(n);
        check("left_after_tick", cur_x, 2);

        // Tick during a scan is held pending and served right after
        send_cmd(3'd0);
        grav_tick = 1'b1;
        step(1);
        grav_tick = 1'b0;
        wait_idle(n);
        check("pending_cycles", n, 32);
        check("pending_x", cur_x, 1);
        check("pending_y", cur_y, 2);

        // Hard drop onto an occupied cell at (2,10): stops at y=8
        board[10][2] = 1'b1;
        send_cmd(3'd5);
        wait_idle(n);
        check("hd_block_lock", lock_valid, 1);
        check("hd_block_y", cur_y, 8);
        step(3);
        check("lock_hold_valid", lock_valid, 1);
        check("lock_hold_y", cur_y, 8);
        check("lock_no_spawn", spawn_ready, 0);
        ack_lock();
        check("ack_spawn_ready", spawn_ready, 1);
        check("ack_cur_live", cur_live, 0);
        check("ack_lock_valid", lock_valid, 0);
        board[10][2] = 1'b0;

        // I to the left wall, then one LEFT too many
        do_spawn(3'd0);
        wait_idle(n);
        for (int i = 0; i < 3; i++) begin
            send_cmd(3'd0);
            wait_idle(n);
        end
        check("i_at_wall", cur_x, 0);
        send_cmd(3'd0);
        wait_idle(n);
        check("i_wall_fail_cycles", n, 5);
        check("i_wall_x", cur_x, 0);
        check("i_wall_active", cmd_ready, 1);
        ack_lock();
        check("stray_ack_live", cur_live, 1);
        check("stray_ack_no_lock", lock_valid, 0);
        send_cmd(3'd5);
        wait_idle(n);
        check("i_hd_y", cur_y, 18);
        check("i_hd_lock", lock_valid, 1);
        ack_lock();

        // Hard drop O from the top of an empty board
        do_spawn(3'd3);
        wait_idle(n);
        send_cmd(3'd5);
        wait_idle(n);
        check("o_hd_y", cur_y, 18);
        check("o_hd_lock", lock_valid, 1);
        ack_lock();

        // O soft-dropped to y=18, then a gravity tick locks it
        do_spawn(3'd3);
        wait_idle(n);
        for (int i = 0; i < 18; i++) begin
            send_cmd(3'd4);
            wait_idle(n);
        end
        check("o_soft_y", cur_y, 18);
        check("o_soft_live", cmd_ready, 1);
        grav_tick = 1'b1;
        step(1);
        grav_tick = 1'b0;
        wait_idle(n);
        check("o_floor_cycles", n, 6);
        check("o_floor_lock", lock_valid, 1);
        check("o_floor_y", cur_y, 18);
        ack_lock();
        check("o_floor_empty", spawn_ready, 1);

        // Spawn blocked at (4,1): game over, sticky
        board[1][4] = 1'b1;
        do_spawn(3'd5);
        wait_idle(n);
        check("over_cycles", n, 6);
        check("over_flag", game_over, 1);
        check("over_spawn_ready", spawn_ready, 0);
        check("over_cur_live", cur_live, 0);
        spawn_valid = 1'b1;
        grav_tick   = 1'b1;
        step(5);
        spawn_valid = 1'b0;
        grav_tick   = 1'b0;
        check("over_sticky", game_over, 1);
        check("over_still_no_spawn", spawn_ready, 0);
        check("over_no_cmd", cmd_ready, 0);

        // Asynchronous reset clears game over
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_over", game_over, 0);
        step(1);
        rst = 1'b0;
        check("rst_after_over", spawn_ready, 1);
        board[1][4] = 1'b0;

        // Reset mid-scan: nothing committed
        do_spawn(3'd5);
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        check("mid_rst_live", cur_live, 0);
        check("mid_rst_x", cur_x, 0);
        check("mid_rst_ready", spawn_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
